adder_pipe: RTL
===============

Name: adder_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle combinational adder in the Small-MIPS datapath.
- Splits a WIDTH-bit add/subtract into WIDTH/SEG carry-chained segments, one segment per register stage.
- Flow control is a valid/ready handshake, so the block can sit between issue logic and a writeback stage that may stall.
- Produces result, carry-out and signed overflow.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SEG.
- SEG, 8, bits added per pipeline stage; NSTG = WIDTH/SEG stages (default 4).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  operands present this cycle.
- o_ready  output  1  block accepts operands this cycle.
- i_op1  input  WIDTH  operand A (two's complement or unsigned).
- i_op2  input  WIDTH  operand B.
- i_c0  input  1  carry-in (add) / borrow-in (sub).
- i_sub  input  1  0 = A+B+c0, 1 = A-B-c0.
- o_valid  output  1  result available.
- i_ready  input  1  downstream accepts result.
- o_result  output  WIDTH  sum/difference.
- o_carry  output  1  carry-out of MSB (sub: 1 = no borrow).
- o_ov  output  1  signed overflow.

Behaviour:
- Reset (i_rst=1 at clock edge):
  - All stage valid bits cleared; o_valid=0, o_result=0, o_carry=0, o_ov=0.
  - Reset mid-operation discards all in-flight operations without producing an output.
  - o_ready=1 from the first cycle after reset.
- Transfer rules:
  - Input transfer when i_valid & o_ready; output transfer when o_valid & i_ready.
- Stall:
  - Global advance enable adv = !o_valid | i_ready; o_ready = adv.
  - When adv=0, every stage holds its contents, including operands and partial results.
- Arithmetic:
  - B' = i_sub ? ~i_op2 : i_op2; cin = i_c0 ^ i_sub.
  - Stage k (k=0..NSTG-1) adds bits [k*SEG +: SEG] of A and B' using the carry registered from stage k-1 (cin for k=0).
  - Upper, not-yet-added operand bits travel with the stage registers.
  - Lower result bits are carried forward unchanged.
- Flags:
  - o_carry = carry out of bit WIDTH-1.
  - o_ov = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Latency and throughput:
  - Exactly NSTG cycles from input transfer to o_valid, when no stall occurs.
  - Throughput is one operation per cycle; issue order is preserved.
- Bubbles:
  - i_valid=0 with adv=1 inserts a bubble; stages with valid=0 have don't-care data.
  - Outputs hold their last values while o_valid=0, and hold stable while o_valid=1 & i_ready=0.
- Simultaneous events:
  - Input and output transfer in the same cycle are legal; occupancy is unchanged.
  - i_rst overrides all handshakes.
- Elaboration check: WIDTH % SEG != 0 or SEG > WIDTH → $error at elaboration.

Optional Feature:
- Macro: ADDER_PIPE_SATURATE_EN; adds input i_sat (1 bit).
- With macro and i_sat=1, the value registered into o_result is saturated:
  - Signed overflow (o_ov=1): result clamps to 0x7FFF_FFFF if A's MSB was 0, 0x8000_0000 if 1 (WIDTH-scaled).
  - o_carry and o_ov still report the raw, unsaturated values.
  - i_sat is pipelined alongside the operation.
- Without macro: no i_sat port; o_result is always the wrapped modular result.

Decomposition:
- Shared package adder_pkg holds:
  - Default-width localparams (DATA_W=32, ADD_SEG_W=8).
  - The op-mode encoding constants OP_ADD=1'b0, OP_SUB=1'b1.
- Natural sub-module: adder_seg, a combinational SEG-bit slice with ports a, b, ci, s, co, c_msb (carry into slice MSB).
  - Instantiated NSTG times via generate.
  - adder_pipe owns all registers and the handshake.

Test Plan (WIDTH=32, SEG=8):
- A=-12, B=15, c0=0, sub=0, i_ready=1 → exactly 4 cycles later: o_valid=1, result=3, carry=1, ov=0.
- A=0xFFFF_FFFE, B=5, c0=0 → result=3, carry=1; then same with c0=1 → result=4; back-to-back issue yields valid on consecutive cycles.
- A=0x7FFF_FFFF, B=1 → result=0x8000_0000, ov=1, carry=0; with ADDER_PIPE_SATURATE_EN and i_sat=1 → result=0x7FFF_FFFF, ov=1.
- sub=1, A=5, B=7, c0=0 → result=0xFFFF_FFFE, carry=0, ov=0; A=0x8000_0000, B=1 → result=0x7FFF_FFFF, ov=1.
- Backpressure: issue 6 ops with i_valid=1 continuously, hold i_ready=0 for 3 cycles after the first o_valid → o_ready drops, no op lost or duplicated, results in order, o_result stable while stalled.
- Assert i_rst for 1 cycle with 3 ops in flight → o_valid=0 the next cycle, none of the 3 results ever appears, new op issued afterwards emerges after 4 cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder.
// Holds the default datapath and segment widths plus the op-mode encoding.
package adder_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADD_SEG_W = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG-bit adder slice.
//   a, b  : slice operands
//   ci    : carry into bit 0 of the slice
//   s     : slice sum
//   co    : carry out of the slice MSB
//   c_msb : carry into the slice MSB (used for signed overflow)
module adder_seg
  import adder_pkg::*;
#(
  parameter int unsigned SEG = ADD_SEG_W
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb
);

  logic [SEG:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
  assign s   = sum[SEG-1:0];
  assign co  = sum[SEG];
  // The carry into the MSB is recovered from the MSB sum bit and its operands.
  assign c_msb = sum[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract with valid/ready flow control.
// The add is split into NSTG = WIDTH/SEG carry-chained segments, one per
// register stage; exactly NSTG cycles of latency, one op per cycle.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_valid / o_ready   : operand handshake
//   i_op1, i_op2, i_c0  : operands and carry/borrow in
//   i_sub               : 0 = A+B+c0, 1 = A-B-c0
//   o_valid / i_ready   : result handshake
//   o_result, o_carry, o_ov : sum, MSB carry-out, signed overflow
// Build option ADDER_PIPE_SATURATE_EN adds i_sat: saturate o_result on
// signed overflow (flags still report the raw values).
module adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned SEG   = ADD_SEG_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  input  logic             i_c0,
  input  logic             i_sub,
`ifdef ADDER_PIPE_SATURATE_EN
  input  logic             i_sat,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_ov
);

  localparam int unsigned NSTG = WIDTH / SEG;

  if ((SEG == 0) || ((WIDTH % SEG) != 0) || (SEG > WIDTH)) begin : g_bad_cfg
    $error("adder_pipe: WIDTH must be a nonzero multiple of SEG");
  end

  logic adv;

  // Stage registers: operands travel with the partial result.
  logic             vld_q [NSTG];
  logic [WIDTH-1:0] a_q   [NSTG];
  logic [WIDTH-1:0] b_q   [NSTG];
  logic [WIDTH-1:0] res_q [NSTG];
  logic             cy_q  [NSTG];
  logic             ov_q  [NSTG];

  // Stage inputs (previous stage register, or the primary inputs for stage 0).
  logic             src_v   [NSTG];
  logic [WIDTH-1:0] src_a   [NSTG];
  logic [WIDTH-1:0] src_b   [NSTG];
  logic [WIDTH-1:0] src_res [NSTG];
  logic             src_cy  [NSTG];

  // Stage next-state values.
  logic [SEG-1:0]   seg_s   [NSTG];
  logic             seg_co  [NSTG];
  logic             seg_cm  [NSTG];
  logic [WIDTH-1:0] nxt_res [NSTG];
  logic             nxt_ov  [NSTG];

`ifdef ADDER_PIPE_SATURATE_EN
  logic sat_q   [NSTG];
  logic src_sat [NSTG];
`endif

  assign o_valid  = vld_q[NSTG-1];
  assign o_result = res_q[NSTG-1];
  assign o_carry  = cy_q[NSTG-1];
  assign o_ov     = ov_q[NSTG-1];

  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg

    logic [WIDTH-1:0] res_w;

    if (k == 0) begin : g_src_in
      assign src_v[k]   = i_valid;
      assign src_a[k]   = i_op1;
      assign src_b[k]   = (i_sub == OP_ADD) ? i_op2 : ~i_op2;
      assign src_res[k] = '0;
      assign src_cy[k]  = i_c0 ^ i_sub;
`ifdef ADDER_PIPE_SATURATE_EN
      assign src_sat[k] = i_sat;
`endif
    end else begin : g_src_reg
      assign src_v[k]   = vld_q[k-1];
      assign src_a[k]   = a_q[k-1];
      assign src_b[k]   = b_q[k-1];
      assign src_res[k] = res_q[k-1];
      assign src_cy[k]  = cy_q[k-1];
`ifdef ADDER_PIPE_SATURATE_EN
      assign src_sat[k] = sat_q[k-1];
`endif
    end

    adder_seg #(
      .SEG (SEG)
    ) u_seg (
      .a     (src_a[k][k*SEG +: SEG]),
      .b     (src_b[k][k*SEG +: SEG]),
      .ci    (src_cy[k]),
      .s     (seg_s[k]),
      .co    (seg_co[k]),
      .c_msb (seg_cm[k])
    );

    always_comb begin
      res_w                 = src_res[k];
      res_w[k*SEG +: SEG]   = seg_s[k];
    end

    assign nxt_ov[k] = seg_cm[k] ^ seg_co[k];

`ifdef ADDER_PIPE_SATURATE_EN
    if (k == NSTG - 1) begin : g_sat
      assign nxt_res[k] = (src_sat[k] && nxt_ov[k])
                        ? {src_a[k][WIDTH-1], {(WIDTH-1){~src_a[k][WIDTH-1]}}}
                        : res_w;
    end else begin : g_nosat
      assign nxt_res[k] = res_w;
    end
`else
    assign nxt_res[k] = res_w;
`endif

    // Data only loads with a valid op so the output stage holds across bubbles.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
        cy_q[k]  <= 1'b0;
        ov_q[k]  <= 1'b0;
`ifdef ADDER_PIPE_SATURATE_EN
        sat_q[k] <= 1'b0;
`endif
      end else if (adv) begin
        vld_q[k] <= src_v[k];
        if (src_v[k]) begin
          a_q[k]   <= src_a[k];
          b_q[k]   <= src_b[k];
          res_q[k] <= nxt_res[k];
          cy_q[k]  <= seg_co[k];
          ov_q[k]  <= nxt_ov[k];
`ifdef ADDER_PIPE_SATURATE_EN
          sat_q[k] <= src_sat[k];
`endif
        end
      end
    end

  end

endmodule
